imm_ctrl_fsm: RTL and testbench

- Multicycle control FSM that sequences instruction capture, decode, execute and writeback for the I-type ALU and B-type branch subset.
- Latches each fetched instruction into an internal instruction register and drives it to the immediate sign-extender.
- Selects the immediate format (immsrc) and the ALU, register-file and PC controls for each instruction.
- Sits between instruction memory and the existing single-cycle datapath blocks.

---
 rtl/imm_ctrl_fsm.sv | 217 +++++++++++++++++++++
 tb/tb_imm_ctrl_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ctrl_fsm.sv
// imm_ctrl_fsm: multicycle control FSM for the ADDI / BEQ / BNE subset.
// It fetches an instruction, latches it into the instruction register, decodes it,
// and then sequences the execute and writeback phases.
//
// Ports:
//   clk, rst      rising-edge clock and synchronous active-high reset
//   imem_ack      instruction memory returns valid data this cycle
//   imem_rdata    instruction word, valid when imem_ack=1
//   eq            ALU zero flag (rs1==rs2), used while a branch resolves
//   imem_req      fetch request
//   ir            latched instruction, sent to the sign-extender and regfile
//   immsrc        1=I-type immediate, 0=B-type immediate
//   alusrc        1=ALU operand B is the immediate, 0=register
//   aluctrl       000=ADD, 001=SUB
//   regwrite      regfile write enable
//   pc_en         PC update enable
//   pcsrc         1=PC+imm (taken branch), 0=PC+4
//   halt          sticky halt indication
//   err           00 none, 01 illegal instruction, 10 fetch timeout
//   retired       count of completed instructions, wraps silently
module imm_ctrl_fsm #(
    parameter int unsigned I_WIDTH    = 32,
    parameter int unsigned D_WIDTH    = 32,
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               imem_ack,
    input  logic [I_WIDTH-1:0] imem_rdata,
    input  logic               eq,
    output logic               imem_req,
    output logic [I_WIDTH-1:0] ir,
    output logic               immsrc,
    output logic               alusrc,
    output logic [2:0]         aluctrl,
    output logic               regwrite,
    output logic               pc_en,
    output logic               pcsrc,
    output logic               halt,
    output logic [1:0]         err,
    output logic [D_WIDTH-1:0] retired
);

    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT);

    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_ADDI   = 3'b000;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ILL   = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_I,
        S_WB,
        S_EXEC_B,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [I_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic [D_WIDTH-1:0] retired_q, retired_d;

    // Output registers, loaded from the decode of the next state
    logic       imem_req_q, imem_req_d;
    logic       immsrc_q, immsrc_d;
    logic       alusrc_q, alusrc_d;
    logic [2:0] aluctrl_q, aluctrl_d;
    logic       regwrite_q, regwrite_d;
    logic       pc_en_q, pc_en_d;
    logic       br_q, br_d;
    logic       halt_q, halt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];

    // Next-state, instruction register, timeout counter, error and retire count
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        retired_d = retired_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    // An ack on the final wait cycle still wins over the timeout
                    ir_d    = imem_rdata;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                    cnt_d   = '0;
                    err_d   = ERR_TMO;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (opcode == OP_ITYPE && funct3 == F3_ADDI) begin
                    state_d = S_EXEC_I;
                end else if (opcode == OP_BRANCH &&
                             (funct3 == F3_BEQ || funct3 == F3_BNE)) begin
                    state_d = S_EXEC_B;
                end else begin
                    err_d   = ERR_ILL;
                    state_d = S_HALT;
                end
            end
            S_EXEC_I: state_d = S_WB;
            S_WB: begin
                retired_d = retired_q + D_WIDTH'(1);
                state_d   = S_FETCH;
            end
            S_EXEC_B: begin
                retired_d = retired_q + D_WIDTH'(1);
                state_d   = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore output decode of the next state so outputs come straight from flops
    always_comb begin
        imem_req_d = 1'b0;
        immsrc_d   = 1'b0;
        alusrc_d   = 1'b0;
        aluctrl_d  = ALU_ADD;
        regwrite_d = 1'b0;
        pc_en_d    = 1'b0;
        br_d       = 1'b0;
        halt_d     = 1'b0;
        unique case (state_d)
            S_FETCH:  imem_req_d = 1'b1;
            S_DECODE: immsrc_d   = (ir_d[6:0] == OP_ITYPE);
            S_EXEC_I: begin
                immsrc_d = 1'b1;
                alusrc_d = 1'b1;
            end
            S_WB: begin
                immsrc_d   = 1'b1;
                alusrc_d   = 1'b1;
                regwrite_d = 1'b1;
                pc_en_d    = 1'b1;
            end
            S_EXEC_B: begin
                aluctrl_d = ALU_SUB;
                pc_en_d   = 1'b1;
                br_d      = 1'b1;
            end
            S_HALT:   halt_d = 1'b1;
            default:  imem_req_d = 1'b0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            cnt_q      <= '0;
            err_q      <= ERR_NONE;
            retired_q  <= '0;
            imem_req_q <= 1'b1;
            immsrc_q   <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctrl_q  <= ALU_ADD;
            regwrite_q <= 1'b0;
            pc_en_q    <= 1'b0;
            br_q       <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            retired_q  <= retired_d;
            imem_req_q <= imem_req_d;
            immsrc_q   <= immsrc_d;
            alusrc_q   <= alusrc_d;
            aluctrl_q  <= aluctrl_d;
            regwrite_q <= regwrite_d;
            pc_en_q    <= pc_en_d;
            br_q       <= br_d;
            halt_q     <= halt_d;
        end
    end

    // Reset forces every output low in the reset cycle, so an instruction
    // caught mid-flight never writes the regfile or moves the PC.
    assign imem_req = imem_req_q & ~rst;
    assign ir       = rst ? '0 : ir_q;
    assign immsrc   = immsrc_q & ~rst;
    assign alusrc   = alusrc_q & ~rst;
    assign aluctrl  = rst ? ALU_ADD : aluctrl_q;
    assign regwrite = regwrite_q & ~rst;
    assign pc_en    = pc_en_q & ~rst;
    assign halt     = halt_q & ~rst;
    assign err      = rst ? ERR_NONE : err_q;
    assign retired  = rst ? '0 : retired_q;

    // Branch direction resolves on the live eq flag; funct3[0] selects BNE.
    assign pcsrc = br_q & ~rst & (eq ^ ir_q[12]);

endmodule

// File: tb/tb_imm_ctrl_fsm.sv
// Directed bench for imm_ctrl_fsm with a per-cycle expectation queue.
module tb_imm_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        eq;
    logic        imem_req;
    logic [31:0] ir;
    logic        immsrc;
    logic        alusrc;
    logic [2:0]  aluctrl;
    logic        regwrite;
    logic        pc_en;
    logic        pcsrc;
    logic        halt;
    logic [1:0]  err;
    logic [31:0] retired;

    imm_ctrl_fsm #(
        .I_WIDTH   (32),
        .D_WIDTH   (32),
        .WAIT_LIMIT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .eq        (eq),
        .imem_req  (imem_req),
        .ir        (ir),
        .immsrc    (immsrc),
        .alusrc    (alusrc),
        .aluctrl   (aluctrl),
        .regwrite  (regwrite),
        .pc_en     (pc_en),
        .pcsrc     (pcsrc),
        .halt      (halt),
        .err       (err),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic        imm;
        logic        asrc;
        logic [2:0]  aluc;
        logic        rw;
        logic        pce;
        logic        pcs;
        logic        hlt;
        logic [1:0]  er;
        logic [31:0] ir;
        logic [31:0] ret;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_ir  = 32'h0;
    logic [31:0] m_ret = 32'h0;

    localparam logic [31:0] W_ADDI = 32'h00500093;
    localparam logic [31:0] W_BEQ  = 32'h00000463;
    localparam logic [31:0] W_BNE  = 32'h00001463;
    localparam logic [31:0] W_RTYP = 32'h00000033;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic req, imm, asrc, input logic [2:0] aluc,
                                input logic rw, pce, pcs, hlt, input logic [1:0] er);
        exp_t e;
        e.req  = req;
        e.imm  = imm;
        e.asrc = asrc;
        e.aluc = aluc;
        e.rw   = rw;
        e.pce  = pce;
        e.pcs  = pcs;
        e.hlt  = hlt;
        e.er   = er;
        e.ir   = m_ir;
        e.ret  = m_ret;
        return e;
    endfunction

    task automatic check_front();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".imem_req"}, 32'(imem_req), 32'(e.req));
            chk({t, ".immsrc"},   32'(immsrc),   32'(e.imm));
            chk({t, ".alusrc"},   32'(alusrc),   32'(e.asrc));
            chk({t, ".aluctrl"},  32'(aluctrl),  32'(e.aluc));
            chk({t, ".regwrite"}, 32'(regwrite), 32'(e.rw));
            chk({t, ".pc_en"},    32'(pc_en),    32'(e.pce));
            chk({t, ".pcsrc"},    32'(pcsrc),    32'(e.pcs));
            chk({t, ".halt"},     32'(halt),     32'(e.hlt));
            chk({t, ".err"},      32'(err),      32'(e.er));
            chk({t, ".ir"},       ir,            e.ir);
            chk({t, ".retired"},  retired,       e.ret);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, compare at the falling edge
    task automatic step(input logic ack, input logic [31:0] rd, input logic e,
                        input string tag, input exp_t ex);
        imem_ack   = ack;
        imem_rdata = rd;
        eq         = e;
        exp_q.push_back(ex);
        tag_q.push_back(tag);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst   = 1'b1;
        m_ir  = 32'h0;
        m_ret = 32'h0;
        step(1'b0, 32'h0, 1'b1, tag, mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        rst = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] w, input string tag);
        step(1'b1, w, 1'b0, {tag, "_fetch"}, mk(1, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        m_ir = w;
    endtask

    task automatic addi(input string tag);
        fetch(W_ADDI, tag);
        step(1'b0, 32'h0, 1'b0, {tag, "_decode"}, mk(0, 1, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        step(1'b0, 32'h0, 1'b0, {tag, "_exec"},   mk(0, 1, 1, 3'b000, 0, 0, 0, 0, 2'b00));
        step(1'b0, 32'h0, 1'b0, {tag, "_wb"},     mk(0, 1, 1, 3'b000, 1, 1, 0, 0, 2'b00));
        m_ret = m_ret + 32'd1;
    endtask

    task automatic branch(input logic [31:0] w, input logic eqv, input logic exp_pcs,
                          input string tag);
        fetch(w, tag);
        step(1'b0, 32'h0, ~eqv, {tag, "_decode"}, mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        step(1'b0, 32'h0, eqv,  {tag, "_exec"},   mk(0, 0, 0, 3'b001, 0, 1, exp_pcs, 0, 2'b00));
        m_ret = m_ret + 32'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        eq         = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset0");

        addi("addi1");
        branch(W_BEQ, 1'b1, 1'b1, "beq_eq1");
        branch(W_BEQ, 1'b0, 1'b0, "beq_eq0");
        branch(W_BNE, 1'b1, 1'b0, "bne_eq1");
        branch(W_BNE, 1'b0, 1'b1, "bne_eq0");

        // Illegal R-type: halt with err=01, later acks ignored
        fetch(W_RTYP, "rtype");
        step(1'b0, 32'h0, 1'b0, "rtype_decode", mk(0, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        step(1'b0, 32'h0, 1'b0, "rtype_halt",   mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 2'b01));
        step(1'b1, W_ADDI, 1'b1, "rtype_ack_ignored", mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 2'b01));
        do_reset("reset_from_halt");
        addi("addi_after_halt");

        // Fetch timeout: 16 unanswered FETCH cycles then halt with err=10
        do_reset("reset_to");
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 32'h0, 1'b0, $sformatf("to_wait%0d", i),
                 mk(1, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        end
        step(1'b0, 32'h0, 1'b0, "to_halt",   mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 2'b10));
        step(1'b1, W_BEQ, 1'b0, "to_sticky", mk(0, 0, 0, 3'b000, 0, 0, 0, 1, 2'b10));

        // Ack on the last allowed wait cycle proceeds normally
        do_reset("reset_late");
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 32'h0, 1'b0, $sformatf("late_wait%0d", i),
                 mk(1, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        end
        addi("late_ack");
        branch(W_BNE, 1'b0, 1'b1, "late_bne");

        // Reset during WB of an ADDI aborts the write
        fetch(W_ADDI, "abort");
        step(1'b0, 32'h0, 1'b0, "abort_decode", mk(0, 1, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        step(1'b0, 32'h0, 1'b0, "abort_exec",   mk(0, 1, 1, 3'b000, 0, 0, 0, 0, 2'b00));
        do_reset("abort_wb_rst");
        step(1'b0, 32'h0, 1'b0, "abort_refetch", mk(1, 0, 0, 3'b000, 0, 0, 0, 0, 2'b00));
        addi("addi_final");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
